// File: rtl/fls_pkg.sv
// Definitions shared by the fls generator and its checker.
// Both ends use them to agree on the data width and the sequence phase encoding.
package fls_pkg;

    localparam int FLS_W = 7;
    localparam int DLY_W = 3;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        CALC   = 2'b10
    } fls_state_e;

endpackage

// File: rtl/fls_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping to zero.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fls_checker.sv
// Monitor for the fls sequence generator.
// After each en rising edge it samples f and checks the term against the sequence rule.
module fls_checker
    import fls_pkg::*;
#(
    parameter int W          = FLS_W,
    parameter int SAMPLE_DLY = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     f,
    output logic             chk_valid,
    output logic             chk_err,
    output logic [W-1:0]     expected,
    output logic [CNT_W-1:0] term_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sticky_err
);

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SAMPLE_DLY);

    logic             en_q;
    logic             step;
    logic             sample;
    logic [DLY_W-1:0] dly_cnt;
    logic [W-1:0]     d_cap;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     a_nxt;
    logic [W-1:0]     b_nxt;
    logic [W-1:0]     exp_nxt;
    logic             err_nxt;
    fls_state_e       state;
    fls_state_e       state_nxt;

    assign step   = en & ~en_q;
    assign sample = (dly_cnt == DLY_W'(1));

    // A running delay counter blocks new steps, including one that lands on the expiry cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            dly_cnt <= '0;
            d_cap   <= '0;
        end else begin
            en_q <= en;
            if (dly_cnt != '0) begin
                dly_cnt <= dly_cnt - DLY_W'(1);
            end else if (step) begin
                dly_cnt <= DLY_LOAD;
                d_cap   <= d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_A;
            a     <= '0;
            b     <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
        end
    end

    // History is shifted with the sampled f, so one bad term does not cascade into later errors.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        exp_nxt   = d_cap;
        case (state)
            LOAD_A: begin
                if (sample) begin
                    a_nxt     = f;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (sample) begin
                    b_nxt     = f;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                exp_nxt = a + b;
                if (sample) begin
                    a_nxt = b;
                    b_nxt = f;
                end
            end
            default: state_nxt = LOAD_A;
        endcase
        err_nxt = sample && (f != exp_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_valid  <= 1'b0;
            chk_err    <= 1'b0;
            expected   <= '0;
            sticky_err <= 1'b0;
        end else begin
            chk_valid <= sample;
            chk_err   <= err_nxt;
            if (sample) begin
                expected <= exp_nxt;
            end
            if (err_nxt) begin
                sticky_err <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_term_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample),
        .count (term_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_nxt),
        .count (err_cnt)
    );

endmodule
